timestamp_latch_sched: RTL and testbench

TIMESTAMP_LATCH_SCHED -- requirements
Module: timestamp_latch_sched

---
 rtl/timestamp_latch_sched.sv | 157 +++++++++++++++
 tb/tb_timestamp_latch_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/timestamp_latch_sched.sv
// Latches the free-running ns counter on fval edges, trigger rises and register loads.
// One shared latch port per clk; waiting requests are age-compensated, trigger stamps are queued.
module timestamp_latch_sched #(
  parameter int CLK_PERIOD_NS   = 25,
  parameter int LONG_REG_WD     = 64,
  parameter int TRIG_FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LONG_REG_WD-1:0] iv_timestamp_cnt,
  input  logic                   i_fval,
  input  logic                   i_trig,
  input  logic                   i_timestamp_load,
  input  logic                   i_trig_rd,
  input  logic                   i_err_clr,
  output logic [LONG_REG_WD-1:0] ov_timestamp_u3,
  output logic [LONG_REG_WD-1:0] ov_timestamp_reg,
  output logic [LONG_REG_WD-1:0] ov_timestamp_trig,
  output logic                   o_trig_empty,
  output logic                   o_trig_ovf,
  output logic [2:0]             ov_req_lost
);

  localparam int AW = $clog2(TRIG_FIFO_DEPTH);
  localparam logic [LONG_REG_WD-1:0] C_ONE_CLK = LONG_REG_WD'(CLK_PERIOD_NS);
  localparam logic [LONG_REG_WD-1:0] C_TWO_CLK = LONG_REG_WD'(2 * CLK_PERIOD_NS);
  localparam logic [AW:0]            C_DEPTH   = (AW+1)'(TRIG_FIFO_DEPTH);

  // Source index order is {reg, trig, fval}, matching ov_req_lost.
  logic [2:0]             r_fvalSr;
  logic [2:0]             r_trigSr;
  logic                   r_loadD;
  logic [2:0]             r_pend;
  logic [2:0][1:0]        r_age;
  logic [2:0]             w_newEdge;
  logic [2:0]             w_req;
  logic [2:0]             w_grant;
  logic [2:0]             w_lostSet;
  logic [1:0]             w_grantAge;
  logic [LONG_REG_WD-1:0] w_ageOff;
  logic [LONG_REG_WD-1:0] w_latchVal;

  logic [LONG_REG_WD-1:0] r_fifoMem [TRIG_FIFO_DEPTH];
  logic [AW-1:0]          r_wrPtr;
  logic [AW-1:0]          r_rdPtr;
  logic [AW:0]            r_count;
  logic                   r_ovf;
  logic [2:0]             r_lost;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_ovfSet;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fvalSr <= '0;
      r_trigSr <= '0;
      r_loadD  <= 1'b0;
    end else begin
      r_fvalSr <= {r_fvalSr[1:0], i_fval};
      r_trigSr <= {r_trigSr[1:0], i_trig};
      r_loadD  <= i_timestamp_load;
    end
  end

  always_comb begin
    w_newEdge[0] = r_fvalSr[2] ^ r_fvalSr[1];
    w_newEdge[1] = ~r_trigSr[2] & r_trigSr[1];
    w_newEdge[2] = i_timestamp_load & ~r_loadD;
    w_req        = r_pend | w_newEdge;
    w_lostSet    = r_pend & w_newEdge;
    w_grant      = 3'b000;
    if (w_req[0])      w_grant[0] = 1'b1;
    else if (w_req[1]) w_grant[1] = 1'b1;
    else if (w_req[2]) w_grant[2] = 1'b1;
    // A fresh edge granted immediately has age 0; only waiting requests are compensated.
    w_grantAge = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (w_grant[i] && r_pend[i]) w_grantAge = r_age[i];
    end
    case (w_grantAge)
      2'd1:    w_ageOff = C_ONE_CLK;
      2'd2:    w_ageOff = C_TWO_CLK;
      default: w_ageOff = '0;
    endcase
    w_latchVal = iv_timestamp_cnt - w_ageOff;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= '0;
      r_age  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_grant[i]) begin
          r_pend[i] <= 1'b0;
          r_age[i]  <= 2'd0;
        end else if (r_pend[i]) begin
          if (r_age[i] != 2'd2) r_age[i] <= r_age[i] + 2'd1;
        end else if (w_newEdge[i]) begin
          r_pend[i] <= 1'b1;
          r_age[i]  <= 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ov_timestamp_u3  <= '0;
      ov_timestamp_reg <= '0;
    end else begin
      if (w_grant[0]) ov_timestamp_u3  <= w_latchVal;
      if (w_grant[2]) ov_timestamp_reg <= w_latchVal;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    w_full   = (r_count == C_DEPTH);
    w_empty  = (r_count == '0);
    w_pop    = i_trig_rd & ~w_empty;
    w_push   = w_grant[1] & (~w_full | w_pop);
    w_ovfSet = w_grant[1] & w_full & ~w_pop;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifoMem[r_wrPtr] <= w_latchVal;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_lost  <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_ovf  <= (r_ovf & ~i_err_clr) | w_ovfSet;
      r_lost <= (r_lost & ~{3{i_err_clr}}) | w_lostSet;
    end
  end

  assign ov_timestamp_trig = w_empty ? '0 : r_fifoMem[r_rdPtr];
  assign o_trig_empty      = w_empty;
  assign o_trig_ovf        = r_ovf;
  assign ov_req_lost       = r_lost;

endmodule

// File: tb/tb_timestamp_latch_sched.sv
// Directed bench: inputs and the counter change on the falling edge, outputs are checked there too.
module tb_timestamp_latch_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] cnt;
  logic        fval, trig, load, rd, clr;
  logic [63:0] u3, regTs, trigTs;
  logic        empty, ovf;
  logic [2:0]  lost;
  int          vectorCount = 0;
  int          failCount   = 0;

  always #5 clk = ~clk;

  timestamp_latch_sched dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .iv_timestamp_cnt  (cnt),
    .i_fval            (fval),
    .i_trig            (trig),
    .i_timestamp_load  (load),
    .i_trig_rd         (rd),
    .i_err_clr         (clr),
    .ov_timestamp_u3   (u3),
    .ov_timestamp_reg  (regTs),
    .ov_timestamp_trig (trigTs),
    .o_trig_empty      (empty),
    .o_trig_ovf        (ovf),
    .ov_req_lost       (lost)
  );

  // Each cycle ends on a falling edge; the counter advances 25 ns per clock.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cnt = cnt + 64'd25;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    logic [63:0] popOrder [4];
    popOrder[0] = 64'd10100;
    popOrder[1] = 64'd10150;
    popOrder[2] = 64'd10200;
    popOrder[3] = 64'd20050;

    reset_n = 1'b0; cnt = '0; fval = 1'b1; trig = 1'b0; load = 1'b0; rd = 1'b0; clr = 1'b0;
    applyStimulus(2);
    checkOutput("rst_u3", u3, 64'd0);
    checkOutput("rst_reg", regTs, 64'd0);
    checkOutput("rst_trig", trigTs, 64'd0);
    checkOutput("rst_empty", {63'd0, empty}, 64'd1);
    checkOutput("rst_ovf", {63'd0, ovf}, 64'd0);
    checkOutput("rst_lost", {61'd0, lost}, 64'd0);

    // fval already high at release: rise sampled with cnt=1000, written two edges later.
    cnt = 64'd1000; reset_n = 1'b1;
    applyStimulus(2);
    checkOutput("fval_rise_early", u3, 64'd0);
    applyStimulus(1);
    checkOutput("fval_rise", u3, 64'd1050);

    load = 1'b1; cnt = 64'd500;
    applyStimulus(1);
    checkOutput("reg_load", regTs, 64'd500);
    load = 1'b0;
    applyStimulus(1);

    fval = 1'b0; cnt = 64'd4000;
    applyStimulus(2);
    checkOutput("fval_fall_early", u3, 64'd1050);
    applyStimulus(1);
    checkOutput("fval_fall", u3, 64'd4050);

    // All three sources detected in the cycle where cnt=2000.
    cnt = 64'd1950; fval = 1'b1; trig = 1'b1;
    applyStimulus(2);
    load = 1'b1;
    applyStimulus(1);
    checkOutput("same_u3", u3, 64'd2000);
    checkOutput("same_trig_wait", {63'd0, empty}, 64'd1);
    applyStimulus(1);
    checkOutput("same_trig", trigTs, 64'd2000);
    checkOutput("same_trig_ne", {63'd0, empty}, 64'd0);
    applyStimulus(1);
    checkOutput("same_reg", regTs, 64'd2000);
    fval = 1'b0; trig = 1'b0; load = 1'b0;
    applyStimulus(4);
    checkOutput("same_lost", {61'd0, lost}, 64'd0);
    rd = 1'b1;
    applyStimulus(1);
    rd = 1'b0;
    checkOutput("pop1_empty", {63'd0, empty}, 64'd1);
    checkOutput("pop1_head", trigTs, 64'd0);

    // Five trigger rises with no pops: the fifth is dropped.
    cnt = 64'd10000;
    for (int i = 0; i < 5; i++) begin
      trig = 1'b1;
      applyStimulus(1);
      trig = 1'b0;
      applyStimulus(1);
    end
    applyStimulus(2);
    checkOutput("ovf_set", {63'd0, ovf}, 64'd1);
    checkOutput("ovf_head", trigTs, 64'd10050);
    checkOutput("ovf_ne", {63'd0, empty}, 64'd0);
    clr = 1'b1;
    applyStimulus(1);
    clr = 1'b0;
    checkOutput("ovf_clr", {63'd0, ovf}, 64'd0);

    // Push lands in the same cycle as a pop on a full FIFO.
    cnt = 64'd20000; trig = 1'b1;
    applyStimulus(1);
    trig = 1'b0;
    applyStimulus(1);
    rd = 1'b1;
    applyStimulus(1);
    rd = 1'b0;
    checkOutput("pushpop_ovf", {63'd0, ovf}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_%0d", i), trigTs, popOrder[i]);
      rd = 1'b1;
      applyStimulus(1);
      rd = 1'b0;
    end
    checkOutput("drain_empty", {63'd0, empty}, 64'd1);
    checkOutput("drain_head", trigTs, 64'd0);
    rd = 1'b1;
    applyStimulus(1);
    rd = 1'b0;
    checkOutput("pop_on_empty", {63'd0, empty}, 64'd1);
    checkOutput("pop_on_empty_ovf", {63'd0, ovf}, 64'd0);

    // fval toggles every cycle, starving reg; a second load edge merges into the pending one.
    cnt = 64'd30000; fval = 1'b1;
    applyStimulus(1);
    fval = 1'b0;
    applyStimulus(1);
    fval = 1'b1; load = 1'b1;
    applyStimulus(1);
    fval = 1'b0; load = 1'b0;
    applyStimulus(1);
    fval = 1'b1; load = 1'b1;
    applyStimulus(3);
    checkOutput("lost_reg_held", regTs, 64'd2000);
    checkOutput("lost_u3", u3, 64'd30150);
    checkOutput("lost_bits", {61'd0, lost}, 64'd4);
    applyStimulus(1);
    checkOutput("lost_reg_write", regTs, 64'd30125);
    clr = 1'b1;
    applyStimulus(1);
    clr = 1'b0;
    checkOutput("lost_clr", {61'd0, lost}, 64'd0);
    load = 1'b0;
    applyStimulus(1);

    // Reset while reg and trig requests wait behind fval.
    fval = 1'b0;
    applyStimulus(1);
    fval = 1'b1;
    applyStimulus(1);
    fval = 1'b0; load = 1'b1; trig = 1'b1;
    applyStimulus(1);
    fval = 1'b1;
    applyStimulus(1);
    fval = 1'b0;
    applyStimulus(1);
    checkOutput("prerst_reg", regTs, 64'd30125);
    checkOutput("prerst_empty", {63'd0, empty}, 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_u3", u3, 64'd0);
    checkOutput("midrst_reg", regTs, 64'd0);
    checkOutput("midrst_empty", {63'd0, empty}, 64'd1);
    fval = 1'b0; trig = 1'b0; load = 1'b0;
    applyStimulus(2);
    reset_n = 1'b1;
    applyStimulus(5);
    checkOutput("postrst_reg", regTs, 64'd0);
    checkOutput("postrst_u3", u3, 64'd0);
    checkOutput("postrst_empty", {63'd0, empty}, 64'd1);
    checkOutput("postrst_head", trigTs, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
